// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module  : fifo_rd_pkg
// Brief   : Shared state encoding, default widths and counter sizing helper
//           for the FIFO burst reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_OUT  = 2'd3;

    localparam int DEF_DW    = 16;
    localparam int DEF_ACC_W = 32;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_accum.sv
// ============================================================================
// Module  : fifo_rd_accum
// Brief   : Burst accumulator with clear/add; saturates when
//           FIFO_BURST_READER_SAT_EN is defined, otherwise wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_accum
    import fifo_rd_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [DW-1:0]    din,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] acc_nxt
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;

    assign w_ext = ACC_W'(din);

`ifdef FIFO_BURST_READER_SAT_EN
    logic [ACC_W:0] w_wide;

    always_comb begin
        w_wide  = {1'b0, r_acc} + {1'b0, w_ext};
        acc_nxt = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
    end
`else
    always_comb begin
        acc_nxt = r_acc + w_ext;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (add) begin
            r_acc <= acc_nxt;
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module  : fifo_burst_reader
// Brief   : Reads BURST_LEN words from a synchronous FIFO and returns their
//           sum on a valid/ready port. Option: FIFO_BURST_READER_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int BURST_LEN = 4,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             empty,
    output logic             rd,
    input  logic [DW-1:0]    fifo_dout,
    input  logic             valid,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy,
    output logic             err
);

    localparam int c_CNT_W = cnt_width(BURST_LEN);
    localparam int c_TMO_W = cnt_width(TIMEOUT);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rd;
    logic               w_rd_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMO_W-1:0] r_tcnt;
    logic [ACC_W-1:0]   r_sum;
    logic               r_err;
    logic               w_clr;
    logic               w_add;
    logic               w_last;
    logic               w_tmo;
    logic               w_err_set;
    logic [ACC_W-1:0]   w_acc;
    logic [ACC_W-1:0]   w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // REQ leaves as soon as its read strobe is out; RD is high during REQ.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_REQ;
            ST_REQ:  if (r_rd)  w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (valid) begin
                    w_next_state = w_last ? ST_OUT : ST_REQ;
                end else if (w_tmo) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OUT:  if (sum_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // RD is registered one edge ahead so the FIFO samples it at the end of
    // the REQ cycle and its data lands in the very next (WAIT) cycle.
    always_comb begin
        w_clr     = (r_state == ST_IDLE) && start;
        w_add     = (r_state == ST_WAIT) && valid;
        w_last    = w_add && (r_cnt == c_CNT_W'(BURST_LEN - 1));
        w_tmo     = (r_state == ST_WAIT) && !valid &&
                    (r_tcnt == c_TMO_W'(TIMEOUT - 1));
        w_err_set = (valid && (r_state != ST_WAIT)) || w_tmo;
        w_rd_nxt  = (w_next_state == ST_REQ) && !empty &&
                    !((r_state == ST_REQ) && r_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd   <= 1'b0;
            r_cnt  <= '0;
            r_tcnt <= '0;
            r_sum  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_rd <= w_rd_nxt;

            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_add) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_WAIT) && !valid) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end

            if (w_last) begin
                r_sum <= w_acc_nxt;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    fifo_rd_accum #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .add     (w_add),
        .din     (fifo_dout),
        .acc     (w_acc),
        .acc_nxt (w_acc_nxt)
    );

    assign rd        = r_rd;
    assign sum       = r_sum;
    assign sum_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module  : tb_fifo_burst_reader
// Brief   : Directed bench for fifo_burst_reader with a behavioural FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        empty;
    logic        rd;
    logic [15:0] fifo_dout;
    logic        valid;
    logic [31:0] sum;
    logic        sum_valid;
    logic        sum_ready = 1'b0;
    logic        busy;
    logic        err;

    logic        start2 = 1'b0;
    logic        empty2 = 1'b0;
    logic        rd2;
    logic [15:0] dout2 = 16'h5a5a;
    logic        valid2;
    logic [15:0] sum2;
    logic        sum_valid2;
    logic        sum_ready2 = 1'b0;
    logic        busy2;
    logic        err2;

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr;
    logic        force_empty = 1'b0;
    logic        suppress = 1'b0;
    logic        inject = 1'b0;
    int          rd_cnt = 0;
    int          b2b = 0;
    int          rd_viol = 0;
    logic        rd_prev = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DW(16), .BURST_LEN(4), .ACC_W(32), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .empty(empty), .rd(rd),
        .fifo_dout(fifo_dout), .valid(valid), .sum(sum), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .busy(busy), .err(err)
    );

    fifo_burst_reader #(.DW(16), .BURST_LEN(4), .ACC_W(16), .TIMEOUT(64)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .empty(empty2), .rd(rd2),
        .fifo_dout(dout2), .valid(valid2), .sum(sum2), .sum_valid(sum_valid2),
        .sum_ready(sum_ready2), .busy(busy2), .err(err2)
    );

    assign empty = force_empty || (rd_ptr >= wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 0;
            valid     <= 1'b0;
            fifo_dout <= '0;
        end else begin
            valid <= inject;
            if (rd) begin
                fifo_dout <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
                valid     <= !suppress;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid2 <= 1'b0;
        else        valid2 <= rd2;
    end

    always @(posedge clk) begin
        rd_cnt  <= rd_cnt + int'(rd);
        if (rd && rd_prev) b2b <= b2b + 1;
        if (rd && empty)   rd_viol <= rd_viol + 1;
        rd_prev <= rd;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_sum_valid(input int budget);
        int k = 0;
        while (!sum_valid && k < budget) begin
            tick();
            k++;
        end
        check("sum_valid_seen", 64'(sum_valid), 64'd1);
    endtask

    task automatic handshake();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int rd0;
        int bad;
        int k;
        logic [15:0] exp16;

        repeat (3) tick();
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        rst_n = 1'b1;
        tick();

        // Preloaded FIFO: latency, RD pulse count, result hold under backpressure.
        for (int i = 0; i < 4; i++) push(16'h1fa4);
        rd0 = rd_cnt;
        pulse_start();
        lat = 0;
        bad = 0;
        for (int k2 = 1; k2 <= 20; k2++) begin
            tick();
            if (sum_valid && lat == 0) lat = k2 + 1;  // cycle 1 follows the START edge
            if (lat != 0 && (!sum_valid || sum !== 32'h00007e90)) bad++;
        end
        check("burst_latency", 64'(lat), 64'd9);
        check("burst_sum", 64'(sum), 64'h7e90);
        check("burst_err", 64'(err), 64'd0);
        check("burst_rd_pulses", 64'(rd_cnt - rd0), 64'd4);
        check("burst_rd_b2b", 64'(b2b), 64'd0);
        check("hold_stable", 64'(bad), 64'd0);
        handshake();
        check("ack_sum_valid", 64'(sum_valid), 64'd0);
        check("ack_busy", 64'(busy), 64'd0);

        // SUM_READY outside OUT does nothing.
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check("idle_ready_busy", 64'(busy), 64'd0);

        // EMPTY held for 20 cycles after START.
        force_empty = 1'b1;
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h8000);
        pulse_start();
        rd0 = rd_cnt;
        repeat (20) tick();
        check("empty_no_rd", 64'(rd_cnt - rd0), 64'd0);
        check("empty_busy", 64'(busy), 64'd1);
        force_empty = 1'b0;
        wait_sum_valid(40);
        check("empty_sum", 64'(sum), 64'h8006);
        check("empty_rd_pulses", 64'(rd_cnt - rd0), 64'd4);
        handshake();

        // VALID withheld after an RD: timeout abort keeps the old SUM.
        suppress = 1'b1;
        push(16'h7777);
        pulse_start();
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        suppress = 1'b0;
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_sum_kept", 64'(sum), 64'h8006);
        check("tmo_sum_valid", 64'(sum_valid), 64'd0);
        push(16'h0010); push(16'h0020); push(16'h0030); push(16'h0040);
        pulse_start();
        check("start_clears_err", 64'(err), 64'd0);
        wait_sum_valid(40);
        check("post_tmo_sum", 64'(sum), 64'h00a0);
        handshake();

        // Stray VALID in IDLE flags an error without starting anything.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        check("stray_valid_err", 64'(err), 64'd1);
        check("stray_valid_busy", 64'(busy), 64'd0);

        // 16-bit accumulator: 4 x 0x5a5a.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        while (!sum_valid2 && k < 40) begin
            tick();
            k++;
        end
`ifdef FIFO_BURST_READER_SAT_EN
        exp16 = 16'hffff;
`else
        exp16 = 16'h6968;
`endif
        check("acc16_valid", 64'(sum_valid2), 64'd1);
        check("acc16_sum", 64'(sum2), 64'(exp16));
        sum_ready2 = 1'b1;
        tick();
        sum_ready2 = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        for (int i = 0; i < 4; i++) push(16'h0101);
        pulse_start();
        k = 0;
        while (!rd && k < 20) begin
            tick();
            k++;
        end
        check("mid_rd_seen", 64'(rd), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rd", 64'(rd), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sum_valid", 64'(sum_valid), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_sum", 64'(sum), 64'd0);
        wr_ptr = 0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push(16'h0101);
        pulse_start();
        wait_sum_valid(40);
        check("rerun_sum", 64'(sum), 64'h0404);
        check("rerun_err", 64'(err), 64'd0);
        handshake();

        check("rd_while_empty", 64'(rd_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer-side engine for the team's 16-bit synchronous FIFO read port (RD/DOUT/VALID/EMPTY).
- On START, reads exactly BURST_LEN words one at a time and accumulates their sum.
- Presents the sum on a valid/ready result port.
- Sits between the FIFO and downstream logic. Replaces the random RD toggling used in benches with a protocol-correct reader.

Parameters:
- DW, 16: FIFO data width.
- BURST_LEN, 4: words per burst, legal range 1..255.
- ACC_W, 32: accumulator/SUM width, must be >= DW.
- TIMEOUT, 64: maximum cycles in WAIT before abort, must be >= 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low (0 = reset).
- START  in  1  burst request; sampled only in IDLE.
- EMPTY  in  1  FIFO empty flag.
- RD  out  1  FIFO read strobe; registered; single-cycle pulse.
- FIFO_DOUT  in  DW  FIFO read data; qualified by VALID.
- VALID  in  1  FIFO read-data valid; expected the cycle after RD is sampled high.
- SUM  out  ACC_W  burst sum; stable while SUM_VALID=1.
- SUM_VALID  out  1  result valid.
- SUM_READY  in  1  downstream accepts result.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE. RD, SUM_VALID, BUSY, ERR = 0. SUM, accumulator, word count and timeout counter = 0.
- FIFO read protocol:
  - RD is sampled by the FIFO at the rising edge.
  - FIFO_DOUT/VALID are valid one cycle later.
  - At most one read is outstanding at a time, so peak throughput is 1 word per 2 cycles.
  - RD is never asserted while EMPTY=1.
- State machine:
  - IDLE: when START=1, clear accumulator, count and ERR, then go to REQ.
  - REQ: when EMPTY=0, drive RD<=1 for one cycle and go to WAIT. When EMPTY=1, stay in REQ; there is no timeout in REQ.
  - WAIT: RD<=0. When VALID=1, add FIFO_DOUT (zero-extended to ACC_W) to the accumulator and increment count. If count reaches BURST_LEN, go to OUT; otherwise return to REQ.
  - OUT: SUM_VALID=1 with SUM = accumulator. On SUM_READY=1, SUM_VALID<=0 and go to IDLE.
- Timeout: WAIT has a cycle counter. If TIMEOUT cycles pass without VALID, set ERR=1, discard the partial sum (SUM unchanged) and go to IDLE.
- Unexpected VALID: VALID=1 in IDLE, REQ or OUT sets ERR=1. The data is ignored and the state is unchanged.
- Accumulator arithmetic: wraps modulo 2^ACC_W.
- Latency: for an already-filled FIFO, SUM_VALID rises 2*BURST_LEN+1 cycles after START is sampled.
- START while BUSY is ignored. START held high re-launches on the cycle after the OUT handshake completes.
- SUM_READY high while SUM_VALID=0 has no effect.
- ERR is cleared only by reset or by the next accepted START.
- Reset mid-burst aborts immediately. Any RD already issued is lost, and the bench must reset the FIFO together with this block.

Optional Feature:
- Macro: FIFO_BURST_READER_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1 instead of wrapping.
- Undefined: modulo wrap; no saturation logic is generated.

Decomposition:
- Shared package fifo_rd_pkg:
  - State encoding constants: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3.
  - Default DW/ACC_W constants.
  - Width helper for counter sizing (clog2 of BURST_LEN+1 and TIMEOUT+1).
- One sub-module: fifo_rd_accum, holding the accumulator register, clear, add-enable and the optional saturation logic. The FSM, counters and ports stay in the top module.

Test Plan:
- FIFO preloaded with 4 x 0x1fa4, START pulse -> exactly 4 RD pulses, never back-to-back. SUM_VALID at cycle 9 after START with SUM=0x00007e90, ERR=0.
- EMPTY held 1 for 20 cycles after START, then deasserted -> RD stays 0 while EMPTY=1, then the burst completes normally with the correct SUM.
- SUM_READY held 0 for 10 cycles in OUT -> SUM_VALID and SUM stay constant. SUM_READY=1 -> SUM_VALID drops the next cycle and BUSY drops.
- VALID withheld after an RD for TIMEOUT=64 cycles -> ERR=1, state IDLE, SUM unchanged. Next START clears ERR.
- ACC_W=16, 4 x 0x5a5a -> SUM=0x6968 without FIFO_BURST_READER_SAT_EN, SUM=0xffff with it.
- RST driven low during WAIT (asynchronous, mid-cycle) -> all outputs 0 immediately, no clock edge needed. After release, a new START runs a clean burst.
